// File: rtl/toggle_detect_w32.sv
// Per-bit toggle detector feeding the 32-bit toggle-coverage reporter.
// Optional build macro TOGGLE_DEDUP_EN: pulse each bit only on its first completed toggle.
module toggle_detect_w32 #(
    parameter int WIDTH  = 32,
    parameter int WARMUP = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] signal,
    input  logic             clear,
    output logic [WIDTH-1:0] valid,
    output logic [WIDTH-1:0] covered,
    output logic [CNT_W-1:0] hit_count,
    output logic             all_covered
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam int WC_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = {PC_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    logic [WIDTH-1:0] prev_r;
    logic             armed_r;
    logic [WC_W-1:0]  warm_cnt_r;
    logic [WIDTH-1:0] rise_seen_r;
    logic [WIDTH-1:0] fall_seen_r;
    logic [WIDTH-1:0] covered_r;
    logic [WIDTH-1:0] valid_r;
    logic [CNT_W-1:0] hit_count_r;
    logic             all_covered_r;

    logic [WIDTH-1:0] gate_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] done_s;
    logic [WIDTH-1:0] rise_seen_nx_s;
    logic [WIDTH-1:0] fall_seen_nx_s;
    logic [SUM_W-1:0] sum_s;
    logic [CNT_W-1:0] hit_count_nx_s;

    // Edge detection, toggle completion and saturating count update.
    always_comb begin
        gate_s         = {WIDTH{1'b1}};
        rise_s         = {WIDTH{1'b0}};
        fall_s         = {WIDTH{1'b0}};
        done_s         = {WIDTH{1'b0}};
        rise_seen_nx_s = rise_seen_r;
        fall_seen_nx_s = fall_seen_r;
        sum_s          = {SUM_W{1'b0}};
        hit_count_nx_s = hit_count_r;
`ifdef TOGGLE_DEDUP_EN
        // Once a bit is covered its edges are ignored entirely.
        gate_s = ~covered_r;
`else
        gate_s = {WIDTH{1'b1}};
`endif
        if (armed_r) begin
            rise_s = ~prev_r & signal & gate_s;
            fall_s = prev_r & ~signal & gate_s;
        end else begin
            rise_s = {WIDTH{1'b0}};
            fall_s = {WIDTH{1'b0}};
        end
        done_s         = (rise_seen_r | rise_s) & (fall_seen_r | fall_s);
        rise_seen_nx_s = (rise_seen_r | rise_s) & ~done_s;
        fall_seen_nx_s = (fall_seen_r | fall_s) & ~done_s;
        sum_s          = SUM_W'(hit_count_r) + SUM_W'(popcount(done_s));
        if (sum_s > SUM_W'({CNT_W{1'b1}})) begin
            hit_count_nx_s = {CNT_W{1'b1}};
        end else begin
            hit_count_nx_s = sum_s[CNT_W-1:0];
        end
    end

    // Sample history and warm-up sequencing; clear leaves these alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_r     <= {WIDTH{1'b0}};
            armed_r    <= 1'b0;
            warm_cnt_r <= WC_W'(WARMUP);
        end else begin
            prev_r <= signal;
            if (warm_cnt_r != {WC_W{1'b0}}) begin
                warm_cnt_r <= warm_cnt_r - WC_W'(1);
                armed_r    <= armed_r;
            end else begin
                warm_cnt_r <= warm_cnt_r;
                armed_r    <= 1'b1;
            end
        end
    end

    // Coverage state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            rise_seen_r   <= {WIDTH{1'b0}};
            fall_seen_r   <= {WIDTH{1'b0}};
            covered_r     <= {WIDTH{1'b0}};
            valid_r       <= {WIDTH{1'b0}};
            hit_count_r   <= {CNT_W{1'b0}};
            all_covered_r <= 1'b0;
        end else if (clear) begin
            rise_seen_r   <= {WIDTH{1'b0}};
            fall_seen_r   <= {WIDTH{1'b0}};
            covered_r     <= {WIDTH{1'b0}};
            valid_r       <= {WIDTH{1'b0}};
            hit_count_r   <= {CNT_W{1'b0}};
            all_covered_r <= 1'b0;
        end else begin
            rise_seen_r   <= rise_seen_nx_s;
            fall_seen_r   <= fall_seen_nx_s;
            covered_r     <= covered_r | done_s;
            valid_r       <= done_s;
            hit_count_r   <= hit_count_nx_s;
            all_covered_r <= &covered_r;
        end
    end

    assign valid       = valid_r;
    assign covered     = covered_r;
    assign hit_count   = hit_count_r;
    assign all_covered = all_covered_r;

endmodule

// File: tb/tb_toggle_detect_w32.sv
// Directed table-driven bench for toggle_detect_w32, plus multi-cycle corner sequences.
module tb_toggle_detect_w32;

`ifdef TOGGLE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    typedef struct {
        logic [31:0] sig;
        logic        clr;
        logic [31:0] v;
        logic [31:0] cov;
        logic [15:0] hit;
        logic        allc;
    } vec_t;

    logic        gbl_clk;
    logic        reset;
    logic [31:0] signal;
    logic        clear;
    logic [31:0] valid;
    logic [31:0] covered;
    logic [15:0] hit_count;
    logic        all_covered;
    logic [31:0] valid4;
    logic [31:0] covered4;
    logic [3:0]  hit_count4;
    logic        all_covered4;

    int total;
    int bad;

    toggle_detect_w32 dut (
        .clock(gbl_clk), .reset(reset), .signal(signal), .clear(clear),
        .valid(valid), .covered(covered), .hit_count(hit_count), .all_covered(all_covered)
    );

    toggle_detect_w32 #(.CNT_W(4)) dut4 (
        .clock(gbl_clk), .reset(reset), .signal(signal), .clear(clear),
        .valid(valid4), .covered(covered4), .hit_count(hit_count4), .all_covered(all_covered4)
    );

    initial gbl_clk = 1'b0;
    always #5 gbl_clk = ~gbl_clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [31:0] s, input logic c, input logic [31:0] v,
                                input logic [31:0] cv, input logic [15:0] h, input logic a);
        vec_t r;
        r.sig = s; r.clr = c; r.v = v; r.cov = cv; r.hit = h; r.allc = a;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge gbl_clk);
        #1;
    endtask

    vec_t tbl[22];
    int   pulses;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear = 1'b0;
        signal = 32'h0;

        tbl[0]  = mk(32'h1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[1]  = mk(32'h0, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[2]  = mk(32'h1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[3]  = mk(32'h0, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[4]  = mk(32'h1, 1'b0, 32'h1, 32'h1, 16'd1, 1'b0);
        tbl[5]  = mk(32'h0, 1'b0, 32'h0, 32'h1, 16'd1, 1'b0);
        tbl[6]  = mk(32'h1, 1'b0, DEDUP ? 32'h0 : 32'h1, 32'h1, DEDUP ? 16'd1 : 16'd2, 1'b0);
        tbl[7]  = mk(32'h0, 1'b0, 32'h0, 32'h1, DEDUP ? 16'd1 : 16'd2, 1'b0);
        tbl[8]  = mk(32'h0, 1'b1, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[9]  = mk(32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[10] = mk(32'h0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd32, 1'b0);
        tbl[11] = mk(32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF, 16'd32, 1'b1);
        tbl[12] = mk(32'h0, 1'b1, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[13] = mk(32'h20, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[14] = mk(32'h0, 1'b0, 32'h20, 32'h20, 16'd1, 1'b0);
        tbl[15] = mk(32'h20, 1'b0, 32'h0, 32'h20, 16'd1, 1'b0);
        tbl[16] = mk(32'h0, 1'b0, DEDUP ? 32'h0 : 32'h20, 32'h20, DEDUP ? 16'd1 : 16'd2, 1'b0);
        tbl[17] = mk(32'h0, 1'b1, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[18] = mk(32'h8, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[19] = mk(32'h0, 1'b1, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[20] = mk(32'h8, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0);
        tbl[21] = mk(32'h0, 1'b0, 32'h8, 32'h8, 16'd1, 1'b0);

        // Reset state.
        tick();
        tick();
        chk("reset_valid", valid, 32'h0);
        chk("reset_covered", covered, 32'h0);
        chk("reset_hit", {16'h0, hit_count}, 32'h0);
        chk("reset_allcov", {31'h0, all_covered}, 32'h0);
        reset = 1'b0;

        // Table: warm-up, all-bit toggle, repeated toggle, clear drop.
        for (int i = 0; i < 22; i++) begin
            signal = tbl[i].sig;
            clear  = tbl[i].clr;
            tick();
            chk($sformatf("v%0d_valid", i), valid, tbl[i].v);
            chk($sformatf("v%0d_covered", i), covered, tbl[i].cov);
            chk($sformatf("v%0d_hit", i), {16'h0, hit_count}, {16'h0, tbl[i].hit});
            chk($sformatf("v%0d_allcov", i), {31'h0, all_covered}, {31'h0, tbl[i].allc});
        end
        clear = 1'b0;

        // Saturation: 20 single-bit toggles.
        clear = 1'b1;
        signal = 32'h0;
        tick();
        clear = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            signal = 32'h1;
            tick();
            if (valid4[0]) pulses++;
            signal = 32'h0;
            tick();
            if (valid4[0]) pulses++;
        end
        chk("sat_pulses", pulses, DEDUP ? 32'd1 : 32'd20);
        chk("sat_hit4", {28'h0, hit_count4}, DEDUP ? 32'd1 : 32'd15);
        chk("sat_hit16", {16'h0, hit_count}, DEDUP ? 32'd1 : 32'd20);
        chk("sat_last_pulse4", valid4, DEDUP ? 32'h0 : 32'h1);

        // Reset while bit 7 has only its rise recorded.
        signal = 32'h80;
        tick();
        chk("b7_rise_nopulse", valid, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("b7_warm_valid", valid, 32'h0);
        signal = 32'h0;
        tick();
        chk("b7_fall_valid", valid, 32'h0);
        tick();
        chk("b7_after_valid", valid, 32'h0);
        chk("b7_covered", covered, 32'h0);
        chk("b7_hit", {16'h0, hit_count}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
